demux1x4_tdm: RTL and testbench

Receive end of the 4-channel time-division link that the 4x1 mux drives. Takes one shared WIDTH-bit stream carrying channels 0..3 in rotating slots, aligns to a frame-sync marker, and writes each slot back into its own channel. Presents all four channels together as one registered output frame. Flags sync misalignment and drops lock after repeated errors.

---
 rtl/demux1x4_tdm.sv | 125 ++++++++++++
 tb/tb_demux1x4_tdm.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1x4_tdm.sv
// Receive side of a 4-channel TDM link: aligns to frame_sync, collects four
// slots into shadow registers and presents them as one registered frame.
module demux1x4_tdm #(
    parameter int WIDTH     = 8,
    parameter int ERR_LIMIT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic               frame_sync,
    output logic [4*WIDTH-1:0] out,
    output logic               out_valid,
    output logic               locked,
    output logic [1:0]         slot,
    output logic               sync_err
);

    localparam int CNT_W = (ERR_LIMIT > 1) ? $clog2(ERR_LIMIT) : 1;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   shadow0_q;
    logic [WIDTH-1:0]   shadow1_q;
    logic [WIDTH-1:0]   shadow2_q;
    logic [4*WIDTH-1:0] out_q;
    logic               out_valid_q;
    logic               locked_q;
    logic               sync_err_q;
    logic [1:0]         slot_q;
    logic [CNT_W-1:0]   err_cnt_q;

    logic               sync_beat;
    logic               misaligned;
    logic               err_at_limit;
    logic [CNT_W-1:0]   err_cnt_d;

    assign sync_beat    = din_valid & frame_sync;
    assign misaligned   = sync_beat & (slot_q != 2'd0);
    // err_cnt never exceeds ERR_LIMIT-1, so equality is the "+1 >= limit" test
    assign err_at_limit = (err_cnt_q == CNT_W'(ERR_LIMIT - 1));
    assign err_cnt_d    = err_cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            shadow0_q   <= '0;
            shadow1_q   <= '0;
            shadow2_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            sync_err_q  <= 1'b0;
            slot_q      <= 2'd0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (sync_beat) begin
                        shadow0_q <= din;
                        slot_q    <= 2'd1;
                        state_q   <= LOCKED;
                        locked_q  <= 1'b1;
                        err_cnt_q <= '0;
                    end
                end
                LOCKED: begin
                    if (misaligned) begin
                        sync_err_q <= 1'b1;
                        if (err_at_limit) begin
                            state_q   <= HUNT;
                            locked_q  <= 1'b0;
                            slot_q    <= 2'd0;
                            err_cnt_q <= '0;
                        end else begin
                            err_cnt_q <= err_cnt_d;
                            shadow0_q <= din;
                            slot_q    <= 2'd1;
                        end
                    end else if (din_valid) begin
                        // an aligned sync beat lands here with slot_q == 0
                        case (slot_q)
                            2'd0: begin
                                shadow0_q <= din;
                                slot_q    <= 2'd1;
                            end
                            2'd1: begin
                                shadow1_q <= din;
                                slot_q    <= 2'd2;
                            end
                            2'd2: begin
                                shadow2_q <= din;
                                slot_q    <= 2'd3;
                            end
                            default: begin
                                out_q       <= {din, shadow2_q, shadow1_q, shadow0_q};
                                out_valid_q <= 1'b1;
                                slot_q      <= 2'd0;
                                err_cnt_q   <= '0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_q  <= HUNT;
                    locked_q <= 1'b0;
                    slot_q   <= 2'd0;
                end
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign locked    = locked_q;
    assign slot      = slot_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_demux1x4_tdm.sv
// Directed bench for demux1x4_tdm: one task per scenario, hand-computed
// expected frames and flag values checked after each clocked beat.
module tb_demux1x4_tdm;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_valid;
    logic        frame_sync;
    logic [31:0] out;
    logic        out_valid;
    logic        locked;
    logic [1:0]  slot;
    logic        sync_err;

    int unsigned tests;
    int unsigned fails;

    demux1x4_tdm #(
        .WIDTH     (8),
        .ERR_LIMIT (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .out        (out),
        .out_valid  (out_valid),
        .locked     (locked),
        .slot       (slot),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of input on the falling edge; outputs are sampled 1ns
    // after the rising edge that consumed it.
    task automatic beat(input logic v, input logic fs, input logic [7:0] d);
        @(negedge clk);
        din_valid  = v;
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = 8'h00;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++;
        if (out !== 32'h0) begin
            fails++; $display("FAIL reset_out: got %h want %h", out, 32'h0);
        end
        tests++;
        if ({out_valid, locked, slot, sync_err} !== 5'b0) begin
            fails++; $display("FAIL reset_flags: got %b want %b", {out_valid, locked, slot, sync_err}, 5'b0);
        end
    endtask

    task automatic test_basic_frame();
        beat(1'b1, 1'b1, 8'h11);
        tests++;
        if (locked !== 1'b1 || slot !== 2'd1) begin
            fails++; $display("FAIL basic_lock: got locked=%b slot=%0d want locked=1 slot=1", locked, slot);
        end
        beat(1'b1, 1'b0, 8'h22);
        beat(1'b1, 1'b0, 8'h33);
        tests++;
        if (out_valid !== 1'b0 || slot !== 2'd3) begin
            fails++; $display("FAIL basic_partial: got out_valid=%b slot=%0d want 0,3", out_valid, slot);
        end
        beat(1'b1, 1'b0, 8'h44);
        tests++;
        if (out !== 32'h44332211 || out_valid !== 1'b1) begin
            fails++; $display("FAIL basic_out: got %h/%b want %h/1", out, out_valid, 32'h44332211);
        end
        beat(1'b0, 1'b0, 8'h00);
        tests++;
        if (out !== 32'h44332211 || out_valid !== 1'b0 || slot !== 2'd0) begin
            fails++; $display("FAIL basic_hold: got %h/%b slot=%0d want %h/0 slot=0", out, out_valid, slot, 32'h44332211);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a [4];
        logic [7:0] b [4];
        logic       any_err;
        a = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        b = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        any_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, (i == 0), a[i]);
            any_err = any_err | sync_err;
        end
        tests++;
        if (out !== 32'hA3A2A1A0 || out_valid !== 1'b1) begin
            fails++; $display("FAIL b2b_first: got %h/%b want %h/1", out, out_valid, 32'hA3A2A1A0);
        end
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, (i == 0), b[i]);
            any_err = any_err | sync_err;
            if (i == 0) begin
                tests++;
                if (out_valid !== 1'b0) begin
                    fails++; $display("FAIL b2b_pulse_width: got %b want 0", out_valid);
                end
            end
        end
        tests++;
        if (out !== 32'hB3B2B1B0 || out_valid !== 1'b1) begin
            fails++; $display("FAIL b2b_second: got %h/%b want %h/1", out, out_valid, 32'hB3B2B1B0);
        end
        tests++;
        if (any_err !== 1'b0) begin
            fails++; $display("FAIL b2b_sync_err: got %b want 0", any_err);
        end
    endtask

    task automatic test_hunt_discard();
        logic saw_valid;
        do_reset();
        saw_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 1'b0, 8'h55);
            saw_valid = saw_valid | out_valid;
        end
        tests++;
        if (locked !== 1'b0 || slot !== 2'd0 || out !== 32'h0 || saw_valid !== 1'b0) begin
            fails++; $display("FAIL hunt_discard: got locked=%b slot=%0d out=%h valid_seen=%b want 0,0,%h,0",
                              locked, slot, out, saw_valid, 32'h0);
        end
    endtask

    task automatic test_gap();
        logic saw_valid;
        saw_valid = 1'b0;
        beat(1'b1, 1'b1, 8'h10);
        beat(1'b1, 1'b0, 8'h20);
        for (int i = 0; i < 3; i++) begin
            beat(1'b0, 1'b1, 8'hEE);
            saw_valid = saw_valid | out_valid;
        end
        tests++;
        if (slot !== 2'd2 || saw_valid !== 1'b0 || locked !== 1'b1) begin
            fails++; $display("FAIL gap_idle: got slot=%0d valid_seen=%b locked=%b want 2,0,1", slot, saw_valid, locked);
        end
        beat(1'b1, 1'b0, 8'h30);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL gap_early_valid: got %b want 0", out_valid);
        end
        beat(1'b1, 1'b0, 8'h40);
        tests++;
        if (out !== 32'h40302010 || out_valid !== 1'b1) begin
            fails++; $display("FAIL gap_out: got %h/%b want %h/1", out, out_valid, 32'h40302010);
        end
    endtask

    task automatic test_misalign();
        // first misalignment: resync on the offending beat, keep lock
        beat(1'b1, 1'b1, 8'hC0);
        beat(1'b1, 1'b0, 8'hC1);
        beat(1'b1, 1'b1, 8'hD0);
        tests++;
        if (sync_err !== 1'b1 || slot !== 2'd1 || locked !== 1'b1 || out_valid !== 1'b0 || out !== 32'h40302010) begin
            fails++; $display("FAIL mis1: got err=%b slot=%0d locked=%b valid=%b out=%h want 1,1,1,0,%h",
                              sync_err, slot, locked, out_valid, out, 32'h40302010);
        end
        beat(1'b1, 1'b0, 8'hD1);
        tests++;
        if (sync_err !== 1'b0 || slot !== 2'd2) begin
            fails++; $display("FAIL mis1_pulse: got err=%b slot=%0d want 0,2", sync_err, slot);
        end
        beat(1'b1, 1'b0, 8'hD2);
        beat(1'b1, 1'b0, 8'hD3);
        tests++;
        if (out !== 32'hD3D2D1D0 || out_valid !== 1'b1) begin
            fails++; $display("FAIL mis1_frame: got %h/%b want %h/1", out, out_valid, 32'hD3D2D1D0);
        end
        // completed frame cleared the error count: one more error keeps lock
        beat(1'b1, 1'b1, 8'hE0);
        beat(1'b1, 1'b1, 8'hF0);
        tests++;
        if (sync_err !== 1'b1 || locked !== 1'b1 || slot !== 2'd1) begin
            fails++; $display("FAIL mis_after_frame: got err=%b locked=%b slot=%0d want 1,1,1", sync_err, locked, slot);
        end
        beat(1'b1, 1'b0, 8'hF1);
        beat(1'b1, 1'b1, 8'h90);
        tests++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || slot !== 2'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL mis2_unlock: got err=%b locked=%b slot=%0d valid=%b want 1,0,0,0",
                              sync_err, locked, slot, out_valid);
        end
        beat(1'b1, 1'b0, 8'h91);
        tests++;
        if (sync_err !== 1'b0 || locked !== 1'b0 || slot !== 2'd0) begin
            fails++; $display("FAIL mis2_hunt: got err=%b locked=%b slot=%0d want 0,0,0", sync_err, locked, slot);
        end
        beat(1'b1, 1'b1, 8'h5A);
        beat(1'b1, 1'b0, 8'h5B);
        beat(1'b1, 1'b0, 8'h5C);
        beat(1'b1, 1'b0, 8'h5D);
        tests++;
        if (out !== 32'h5D5C5B5A || out_valid !== 1'b1 || locked !== 1'b1) begin
            fails++; $display("FAIL relock: got %h/%b locked=%b want %h/1 locked=1", out, out_valid, locked, 32'h5D5C5B5A);
        end
    endtask

    task automatic test_reset_midframe();
        beat(1'b1, 1'b1, 8'h71);
        beat(1'b1, 1'b0, 8'h72);
        beat(1'b1, 1'b0, 8'h73);
        @(negedge clk);
        din_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        tests++;
        if (out !== 32'h0 || slot !== 2'd0 || locked !== 1'b0) begin
            fails++; $display("FAIL async_reset: got out=%h slot=%0d locked=%b want %h,0,0", out, slot, locked, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        beat(1'b1, 1'b1, 8'h01);
        beat(1'b1, 1'b0, 8'h02);
        beat(1'b1, 1'b0, 8'h03);
        beat(1'b1, 1'b0, 8'h04);
        tests++;
        if (out !== 32'h04030201 || out_valid !== 1'b1) begin
            fails++; $display("FAIL post_reset_frame: got %h/%b want %h/1", out, out_valid, 32'h04030201);
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b1;
        din        = 8'h00;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_hunt_discard();
        test_gap();
        test_misalign();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
